// File: rtl/nios_oci_arb_pkg.sv
// Shared types and jdo field offsets for the OCI debug RAM access arbiter.
package nios_oci_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    J_ACC,
    J_RD,
    C_ACC,
    C_RD
  } arb_state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_JTAG
  } grant_e;

  localparam int unsigned ADDR_LSB  = 17;
  localparam int unsigned WDATA_LSB = 3;
  localparam int unsigned RDREQ_BIT = 35;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned JDO_W     = 38;

endpackage

// File: rtl/nios_oci_jtag_cmd_slot.sv
// Decodes the JTAG sysclk strobes into a one-deep command slot with an
// auto-incrementing address pointer and a sticky overrun flag.
module nios_oci_jtag_cmd_slot
  import nios_oci_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              take_a_i,
  input  logic              take_b_i,
  input  logic              take_rd_i,
  input  logic [JDO_W-1:0]  jdo_i,
  input  logic              retire_i,
  output logic              valid_o,
  output logic              write_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              overrun_o
);

  logic              valid_q, valid_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              overrun_q, overrun_d;
  logic              free;

  // A strobe may land in the same cycle the held command retires.
  assign free = ~valid_q | retire_i;

  always_comb begin
    valid_d   = valid_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    if (retire_i) begin
      valid_d = 1'b0;
      ptr_d   = ptr_q + ADDR_W'(1);
    end
    if (take_a_i) begin
      if (free) begin
        ptr_d     = jdo_i[ADDR_LSB +: ADDR_W];
        overrun_d = 1'b0;
        if (jdo_i[RDREQ_BIT]) begin
          valid_d = 1'b1;
          write_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (take_b_i) begin
      if (free) begin
        valid_d = 1'b1;
        write_d = 1'b1;
        wdata_d = jdo_i[WDATA_LSB +: DATA_W];
      end else begin
        overrun_d = 1'b1;
      end
    end else if (take_rd_i) begin
      if (free) begin
        valid_d = 1'b1;
        write_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign write_o   = write_q;
  assign wdata_o   = wdata_q;
  assign ptr_o     = ptr_q;
  assign overrun_o = overrun_q;

  logic unused_jdo;
  assign unused_jdo = ^{jdo_i[37:36], jdo_i[2:0]};

endmodule

// File: rtl/nios_oci_access_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG commands and the
// CPU-side Avalon debug slave, with registered RAM controls.
module nios_oci_access_arbiter
  import nios_oci_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned JTAG_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata
);

  arb_state_e        state_q, state_d;
  grant_e            last_q, last_d;
  logic              cpu_wr_q, cpu_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [31:0]       mon_q, mon_d;

  logic              slot_valid, slot_write, slot_overrun;
  logic [31:0]       slot_wdata;
  logic [ADDR_W-1:0] slot_ptr;
  logic              cpu_req, jtag_wins, jtag_done;

  assign cpu_req   = avs_read | avs_write;
  assign jtag_wins = (JTAG_PRIORITY != 0) || (last_q == GNT_CPU);
  // A JTAG write completes in J_ACC (ram_we_q marks it); a read completes in J_RD.
  assign jtag_done = ((state_q == J_ACC) && ram_we_q) || (state_q == J_RD);

  nios_oci_jtag_cmd_slot #(
    .ADDR_W(ADDR_W)
  ) u_slot (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .take_a_i  (take_action_ocimem_a),
    .take_b_i  (take_action_ocimem_b),
    .take_rd_i (take_no_action_ocimem_a),
    .jdo_i     (jdo),
    .retire_i  (jtag_done),
    .valid_o   (slot_valid),
    .write_o   (slot_write),
    .wdata_o   (slot_wdata),
    .ptr_o     (slot_ptr),
    .overrun_o (slot_overrun)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cpu_wr_d    = cpu_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    mon_d       = mon_q;
    unique case (state_q)
      IDLE: begin
        if (slot_valid && (!cpu_req || jtag_wins)) begin
          state_d     = J_ACC;
          ram_addr_d  = slot_ptr;
          ram_wdata_d = slot_wdata;
          ram_we_d    = slot_write;
          ram_re_d    = ~slot_write;
        end else if (cpu_req) begin
          state_d     = C_ACC;
          ram_addr_d  = avs_address;
          ram_wdata_d = avs_writedata;
          ram_we_d    = avs_write;
          ram_re_d    = ~avs_write;
          cpu_wr_d    = avs_write;
        end
      end
      J_ACC: begin
        last_d  = GNT_JTAG;
        state_d = ram_we_q ? IDLE : J_RD;
      end
      J_RD: begin
        mon_d   = ram_rdata;
        state_d = IDLE;
      end
      C_ACC: begin
        last_d  = GNT_CPU;
        state_d = cpu_wr_q ? IDLE : C_RD;
      end
      C_RD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= GNT_CPU;
      cpu_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      mon_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cpu_wr_q    <= cpu_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      mon_q       <= mon_d;
    end
  end

  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign ram_we          = ram_we_q;
  assign ram_re          = ram_re_q;
  assign MonDReg         = mon_q;
  assign jtag_overrun    = slot_overrun;
  assign jtag_busy       = slot_valid | (state_q == J_ACC) | (state_q == J_RD);
  assign avs_readdata    = (state_q == C_RD) ? ram_rdata : 32'h0;
  assign avs_waitrequest = cpu_req & ~(((state_q == C_ACC) & cpu_wr_q) | (state_q == C_RD));

  // Avalon masters must hold the request steady while stalled.
  avs_stable_a: assert property (@(posedge clk) disable iff (!reset_n)
    avs_waitrequest |=> ($stable(avs_read) && $stable(avs_write) &&
                         $stable(avs_address) && $stable(avs_writedata)));

endmodule

// File: tb/tb_nios_oci_access_arbiter.sv
// Directed bench: round-robin instance plus a JTAG-priority instance, each with a RAM model.
module tb_nios_oci_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ta, tb, tn;
  logic [37:0] jdo;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic        sel2;

  logic [31:0] mon1, mon2, rd1, rd2, wd1, wd2, rdata1, rdata2;
  logic        busy1, busy2, ovr1, ovr2, wait1, wait2, we1, we2, re1, re2;
  logic [7:0]  addr1, addr2;
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;
  logic we_seen = 1'b0;

  always #5 clk = ~clk;

  nios_oci_access_arbiter #(.ADDR_W(8), .JTAG_PRIORITY(0)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(ta & ~sel2), .take_action_ocimem_b(tb & ~sel2),
    .take_no_action_ocimem_a(tn & ~sel2), .jdo(jdo),
    .MonDReg(mon1), .jtag_busy(busy1), .jtag_overrun(ovr1),
    .avs_address(avs_address), .avs_read(avs_read & ~sel2), .avs_write(avs_write & ~sel2),
    .avs_writedata(avs_writedata), .avs_readdata(rd1), .avs_waitrequest(wait1),
    .ram_addr(addr1), .ram_wdata(wd1), .ram_we(we1), .ram_re(re1), .ram_rdata(rdata1)
  );

  nios_oci_access_arbiter #(.ADDR_W(8), .JTAG_PRIORITY(1)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(ta & sel2), .take_action_ocimem_b(tb & sel2),
    .take_no_action_ocimem_a(tn & sel2), .jdo(jdo),
    .MonDReg(mon2), .jtag_busy(busy2), .jtag_overrun(ovr2),
    .avs_address(avs_address), .avs_read(avs_read & sel2), .avs_write(avs_write & sel2),
    .avs_writedata(avs_writedata), .avs_readdata(rd2), .avs_waitrequest(wait2),
    .ram_addr(addr2), .ram_wdata(wd2), .ram_we(we2), .ram_re(re2), .ram_rdata(rdata2)
  );

  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wd1;
    if (re1) rdata1 <= mem1[addr1];
    if (we2) mem2[addr2] <= wd2;
    if (re2) rdata2 <= mem2[addr2];
  end

  wire        obs_wait = sel2 ? wait2 : wait1;
  wire [31:0] obs_rd   = sel2 ? rd2 : rd1;
  wire        obs_busy = sel2 ? busy2 : busy1;
  wire        obs_re   = sel2 ? re2 : re1;
  wire        obs_we   = sel2 ? we2 : we1;

  always @(posedge clk) if (mon_en && obs_we) we_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Holds a CPU request until waitrequest drops; checks stall length and read data.
  task automatic cpu_xfer(input logic wr, input logic both, input logic [7:0] a,
                          input logic [31:0] d, input int exp_cyc, input logic [31:0] exp_rd,
                          input string tag);
    int cyc = 0;
    avs_address = a; avs_write = wr; avs_read = ~wr | both; avs_writedata = d;
    @(negedge clk);
    while (obs_wait && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_cyc"}, cyc, exp_cyc);
    if (!wr) check({tag, "_data"}, obs_rd, exp_rd);
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic strobe_a(input logic [7:0] a, input logic rd);
    jdo = '0; jdo[24:17] = a; jdo[35] = rd; ta = 1'b1;
    @(posedge clk); #1;
    ta = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d; tb = 1'b1;
    @(posedge clk); #1;
    tb = 1'b0;
  endtask

  task automatic strobe_n();
    tn = 1'b1;
    @(posedge clk); #1;
    tn = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (obs_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'b0, obs_busy}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    ta = 0; tb = 0; tn = 0; jdo = '0; sel2 = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_mon", mon1, 32'h0);
    check("rst_busy", {31'b0, busy1}, 32'h0);
    check("rst_ovr", {31'b0, ovr1}, 32'h0);
    check("rst_ram", {30'b0, we1, re1}, 32'h0);
    check("rst_wait", {31'b0, wait1}, 32'h0);
    check("rst_rd", rd1, 32'h0);
    @(posedge clk); #1;

    cpu_xfer(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 1, 32'h0, "cpu_wr");
    cpu_xfer(1'b0, 1'b0, 8'h10, 32'h0, 2, 32'hDEADBEEF, "cpu_rd");
    cpu_xfer(1'b1, 1'b1, 8'h11, 32'hCAFEF00D, 1, 32'h0, "cpu_rw");
    check("rw_is_wr", mem1[8'h11], 32'hCAFEF00D);

    strobe_a(8'hFF, 1'b0);
    strobe_b(32'h12345678);
    check("busy_set", {31'b0, busy1}, 32'h1);
    wait_idle("jw1");
    strobe_b(32'h9ABCDEF0);
    wait_idle("jw2");
    check("mem_ff", mem1[8'hFF], 32'h12345678);
    check("mem_00_wrap", mem1[8'h00], 32'h9ABCDEF0);
    strobe_a(8'hFF, 1'b1);
    wait_idle("jr1");
    check("mon_ff", mon1, 32'h12345678);
    strobe_n();
    wait_idle("jr2");
    check("mon_ptr0", mon1, 32'h9ABCDEF0);

    // last_grant = CPU, then a tie: JTAG first, and the follow-on tie goes to the CPU.
    cpu_xfer(1'b1, 1'b0, 8'h50, 32'h0BADF00D, 1, 32'h0, "cpu_pre");
    strobe_b(32'hA1A1A1A1);
    fork
      cpu_xfer(1'b0, 1'b0, 8'h10, 32'h0, 4, 32'hDEADBEEF, "tie_rr");
      begin
        @(posedge clk); #1;
        strobe_b(32'hB2B2B2B2);
      end
    join
    wait_idle("tie");
    check("tie_mem1", mem1[8'h01], 32'hA1A1A1A1);
    check("tie_mem2", mem1[8'h02], 32'hB2B2B2B2);
    check("tie_ovr", {31'b0, ovr1}, 32'h0);

    cpu_xfer(1'b1, 1'b0, 8'h04, 32'h55AA55AA, 1, 32'h0, "cpu_m4");
    strobe_b(32'h11111111);
    strobe_b(32'h22222222);
    wait_idle("ovr");
    check("ovr_set", {31'b0, ovr1}, 32'h1);
    check("ovr_mem3", mem1[8'h03], 32'h11111111);
    check("ovr_mem4", mem1[8'h04], 32'h55AA55AA);
    strobe_a(8'h20, 1'b0);
    @(negedge clk);
    check("ovr_clr", {31'b0, ovr1}, 32'h0);
    @(posedge clk); #1;

    strobe_a(8'h10, 1'b1);
    begin
      int n = 0;
      @(negedge clk);
      while (!obs_re && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("jrd_start", {31'b0, obs_re}, 32'h1);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("midrst_mon", mon1, 32'h0);
    check("midrst_busy", {31'b0, busy1}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_we", {31'b0, we_seen}, 32'h0);
    check("midrst_mon2", mon1, 32'h0);
    check("midrst_busy2", {31'b0, busy1}, 32'h0);
    mon_en = 1'b0;
    cpu_xfer(1'b1, 1'b0, 8'h30, 32'h600DCAFE, 1, 32'h0, "post_wr");
    cpu_xfer(1'b0, 1'b0, 8'h30, 32'h0, 2, 32'h600DCAFE, "post_rd");

    // JTAG_PRIORITY instance: JTAG last granted, still wins both back-to-back ties.
    sel2 = 1'b1;
    @(posedge clk); #1;
    strobe_a(8'h40, 1'b0);
    strobe_b(32'hA0A0A0A0);
    wait_idle("p_pre");
    strobe_b(32'hC0C0C0C0);
    fork
      cpu_xfer(1'b0, 1'b0, 8'h40, 32'h0, 6, 32'hA0A0A0A0, "tie_pri");
      begin
        @(posedge clk); #1;
        strobe_b(32'hD0D0D0D0);
      end
    join
    wait_idle("pri");
    check("pri_mem41", mem2[8'h41], 32'hC0C0C0C0);
    check("pri_mem42", mem2[8'h42], 32'hD0D0D0D0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
